// File: rtl/log2_pkg.sv
`default_nettype none
// ============================================================================
// log2_pkg : shared widths, state encoding and error code for log2_approx
// Revision : 1.0
// ============================================================================
package log2_pkg;

    // Default Q8.8 format, kept identical to the exp2 unit's defaults.
    localparam int LOG2_W  = 16;
    localparam int LOG2_BF = 8;

    // Returned for non-positive operands: the most negative W-bit value.
    localparam logic [LOG2_W-1:0] LOG2_ERR_VAL = {1'b1, {(LOG2_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } log2_state_t;

endpackage
`default_nettype wire

// File: rtl/log2_approx.sv
`default_nettype none
// ============================================================================
// log2_approx : iterative Mitchell log2 of a signed Q(W-Bf).Bf operand.
// Optional LOG2_ERR_CORR_EN adds a one-cycle quadratic mantissa correction.
// Revision    : 1.0
// ============================================================================
module log2_approx
    import log2_pkg::*;
#(
    parameter int FIX_POINT_WIDTH = LOG2_W,
    parameter int Bf              = LOG2_BF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FIX_POINT_WIDTH-1:0] in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIX_POINT_WIDTH-1:0] out,
    output logic                       err
);

    localparam int W  = FIX_POINT_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] C_ERR_VAL = {1'b1, {(W-1){1'b0}}};

    log2_state_t   r_state;
    logic [W-1:0]  r_x;
    logic [CW-1:0] r_cnt;

    logic          w_in_bad;
    logic [Bf-1:0] w_f;
    logic [W-1:0]  w_e;
    logic [W-1:0]  w_res;

    // Exponent e = (W-1-cnt) - Bf, kept as a W-bit two's-complement value.
    always_comb begin
        w_in_bad = in[W-1] | (in == '0);
        w_f      = r_x[W-2 -: Bf];
        w_e      = W'(W - 1 - Bf) - W'(r_cnt);
        w_res    = (w_e << Bf) + W'(w_f);
    end

`ifdef LOG2_ERR_CORR_EN
    localparam int PW = 2 * Bf + 1;

    logic [PW-1:0] w_prod;
    logic [Bf:0]   w_fc_sum;
    logic [Bf-1:0] w_fc;
    logic [W-1:0]  w_res_corr;

    // f' = f + f*(2^Bf - f)/2^(Bf+2), clamped to the largest mantissa.
    always_comb begin
        w_prod     = PW'(w_f) * (PW'(1 << Bf) - PW'(w_f));
        w_fc_sum   = {1'b0, w_f} + (Bf+1)'(w_prod >> (Bf + 2));
        w_fc       = w_fc_sum[Bf] ? {Bf{1'b1}} : w_fc_sum[Bf-1:0];
        w_res_corr = (w_e << Bf) + W'(w_fc);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            r_cnt     <= '0;
            r_x       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x      <= in;
                        in_ready <= 1'b0;
                        if (w_in_bad) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            out       <= C_ERR_VAL;
                            err       <= 1'b1;
                        end else begin
                            r_state <= NORM;
                            r_cnt   <= '0;
                            err     <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!r_x[W-1]) begin
                        r_x   <= r_x << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
`ifdef LOG2_ERR_CORR_EN
                        r_state <= CORR;
`else
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        out       <= w_res;
`endif
                    end
                end
`ifdef LOG2_ERR_CORR_EN
                CORR: begin
                    r_state   <= DONE;
                    out_valid <= 1'b1;
                    out       <= w_res_corr;
                end
`endif
                DONE: begin
                    // Input side reopens only after the result is taken.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/log2_approx.md
Name: log2_approx

Overview:
- Fixed-point base-2 logarithm unit; the inverse of the existing exp2 shift-based approximation.
- Uses the Mitchell approximation: x = 2^e·(1+m), so log2(x) ≈ e + m.
- Iterative leading-one normalisation with valid/ready handshakes on both sides.
- Feeds log-domain paths in the nonlinear function module, e.g. softmax log-sum-exp and root via exp2(log2(x)/2).

Parameters:
- FIX_POINT_WIDTH, 16: total width W of input and output.
- Bf, 8: fractional bits of input and output (two's-complement Q(W-Bf).Bf).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input.
- in  input  W  signed fixed-point operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  W  signed fixed-point log2 result.
- err  output  1  input was ≤ 0; qualified by out_valid.

Behaviour:
- Reset (async, asserted): state=IDLE, in_ready=1, out_valid=0, out=0, err=0, shift count cnt=0.
- States: IDLE, NORM, (CORR when the optional feature is enabled), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in to register x.
  - If in ≤ 0 (MSB set or zero): go to DONE with err=1, out = {1'b1, (W-1)'b0}, the most negative value.
  - Otherwise: go to NORM, cnt=0.
- NORM, one check per cycle:
  - If x[W-1]==0: x <= x<<1, cnt <= cnt+1.
  - Else: go to DONE (or CORR), computing the result.
- Result arithmetic:
  - p = W-1-cnt, the original leading-one position, range 0..W-2.
  - e = p-Bf, signed, range -Bf..W-2-Bf.
  - f = x[W-2 : W-1-Bf].
  - out = (e<<Bf) + f, computed in W-bit signed arithmetic; it never overflows for the given ranges.
- DONE:
  - out_valid=1; out and err held stable until out_ready.
  - On out_ready: out_valid=0, go to IDLE.
  - No new input is accepted in DONE, even when out_ready is high; the next input can be accepted one cycle later.
- in_ready=0 in every state except IDLE.
- Latency:
  - Valid input: out_valid rises cnt+2 edges after the accepting edge (cnt = 15-p, range 1..15 at W=16); +1 with CORR.
  - Error input: out_valid rises 1 edge after the accepting edge.
- Reset mid-operation: the in-flight result is discarded with no out_valid pulse; after release the block returns to IDLE with in_ready=1.
- in changing while not in IDLE has no effect.

Optional Feature:
- Macro LOG2_ERR_CORR_EN.
- Defined:
  - Adds state CORR between NORM and DONE (+1 cycle).
  - f' = f + ((f·(2^Bf - f)) >> (Bf+2)), a 2Bf-bit product, result saturated to 2^Bf-1.
  - out = (e<<Bf) + f'.
  - Reduces Mitchell's error, peak about 0.086, to about 0.02.
- Undefined: no CORR state; plain Mitchell output.

Decomposition:
- Shared package log2_pkg holds:
  - default W and Bf, shared with exp2 users;
  - state enum {IDLE, NORM, CORR, DONE};
  - LOG2_ERR_VAL constant (most negative W-bit value).
- No sub-module is needed: normalisation is an iterative shift and the correction is inline.
- If latency later matters, a leading-zero-detector sub-module lzd_w is the natural split-out.

Test Plan (W=16, Bf=8, feature off unless stated):
- in=0x0100 (1.0) -> out=0x0000, err=0, out_valid 9 edges after accept.
- in=0x0300 (3.0) -> out=0x0180. With LOG2_ERR_CORR_EN -> out=0x0190, one extra cycle.
- in=0x0080 (0.5) -> out=0xFF00 (-1.0). in=0x0001 -> out=0xF800, 17-edge latency. in=0x7FFF -> out=0x06FF, 3-edge latency.
- in=0x0000 and in=0xFF00 -> err=1, out=0x8000, out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out/err stable, in_ready=0; in_valid with new data is ignored until the DONE→IDLE handshake completes.
- Assert rst during NORM (in=0x0001, cycle 4) -> out_valid never pulses; after release, in_ready=1 and the next in=0x0200 yields out=0x0100.
